// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator link: differencer state encoding and default width.
package accum_pkg;

  typedef enum logic {
    ACC_EMPTY  = 1'b0,
    ACC_PRIMED = 1'b1
  } acc_state_e;

  localparam int ACC_WIDTH = 32;

endpackage

// File: rtl/accum_differencer.sv
// Turns a stream of running totals back into per-sample increments d[n] = s[n] - s[n-1],
// with valid/ready on both sides and a single registered output word.
module accum_differencer
  import accum_pkg::*;
#(
  parameter int WIDTH     = ACC_WIDTH,
  parameter bit SEED_ZERO = 1'b1
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_CLEAR,
  input  logic [WIDTH-1:0] i_DATA_IN,
  input  logic             i_VALID,
  output logic             o_READY,
  output logic [WIDTH-1:0] o_DATA_OUT,
  output logic             o_VALID,
  output logic             o_FIRST,
  input  logic             i_READY
);

  function automatic logic [WIDTH-1:0] wrap_sub(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a - b;
  endfunction

  acc_state_e       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             first_q, first_d;
  // Set after a priming sample when SEED_ZERO=0: the next emitted word is the first one.
  logic             pend_first_q, pend_first_d;

  logic in_xfer;
  logic out_xfer;

  assign o_READY    = !i_CLEAR && (!vld_q || i_READY);
  assign in_xfer    = i_VALID && o_READY;
  assign out_xfer   = vld_q && i_READY;
  assign o_DATA_OUT = data_q;
  assign o_VALID    = vld_q;
  assign o_FIRST    = first_q;

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    data_d       = data_q;
    vld_d        = vld_q;
    first_d      = first_q;
    pend_first_d = pend_first_q;

    if (out_xfer) begin
      vld_d = 1'b0;
    end

    if (i_CLEAR) begin
      state_d      = ACC_EMPTY;
      prev_d       = '0;
      vld_d        = 1'b0;
      first_d      = 1'b0;
      pend_first_d = 1'b0;
    end else if (in_xfer) begin
      prev_d  = i_DATA_IN;
      state_d = ACC_PRIMED;
      if (state_q == ACC_EMPTY) begin
        if (SEED_ZERO) begin
          data_d  = i_DATA_IN;
          first_d = 1'b1;
          vld_d   = 1'b1;
        end else begin
          pend_first_d = 1'b1;
        end
      end else begin
        data_d       = wrap_sub(i_DATA_IN, prev_q);
        first_d      = pend_first_q;
        vld_d        = 1'b1;
        pend_first_d = 1'b0;
      end
    end
  end

  // Output / history register stage
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q      <= ACC_EMPTY;
      prev_q       <= '0;
      data_q       <= '0;
      vld_q        <= 1'b0;
      first_q      <= 1'b0;
      pend_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      data_q       <= data_d;
      vld_q        <= vld_d;
      first_q      <= first_d;
      pend_first_q <= pend_first_d;
    end
  end

endmodule

// File: tb/tb_accum_differencer.sv
// Directed and round-trip bench for accum_differencer, one seeded and one priming instance.
module tb_accum_differencer;

  localparam int W = 32;
  localparam int N_RT = 1000;

  logic         i_CLK = 1'b0;
  logic         i_RESET = 1'b0;
  logic         i_CLEAR = 1'b0;
  logic [W-1:0] i_DATA_IN = '0;
  logic         i_VALID = 1'b0;
  logic         i_READY = 1'b0;

  logic         o_READY_s, o_VALID_s, o_FIRST_s;
  logic [W-1:0] o_DATA_OUT_s;
  logic         o_READY_p, o_VALID_p, o_FIRST_p;
  logic [W-1:0] o_DATA_OUT_p;

  int n_vec = 0;
  int n_err = 0;

  accum_differencer #(.WIDTH(W), .SEED_ZERO(1'b1)) u_dut_seed (
    .i_CLK(i_CLK), .i_RESET(i_RESET), .i_CLEAR(i_CLEAR), .i_DATA_IN(i_DATA_IN),
    .i_VALID(i_VALID), .o_READY(o_READY_s), .o_DATA_OUT(o_DATA_OUT_s),
    .o_VALID(o_VALID_s), .o_FIRST(o_FIRST_s), .i_READY(i_READY)
  );

  accum_differencer #(.WIDTH(W), .SEED_ZERO(1'b0)) u_dut_prime (
    .i_CLK(i_CLK), .i_RESET(i_RESET), .i_CLEAR(i_CLEAR), .i_DATA_IN(i_DATA_IN),
    .i_VALID(i_VALID), .o_READY(o_READY_p), .o_DATA_OUT(o_DATA_OUT_p),
    .o_VALID(o_VALID_p), .o_FIRST(o_FIRST_p), .i_READY(i_READY)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic step();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic apply_reset();
    i_RESET = 1'b1;
    i_VALID = 1'b0;
    i_CLEAR = 1'b0;
    step();
    i_RESET = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    i_READY = 1'b0;
    #1;
    n_vec++;
    if (o_VALID_s !== 1'b0 || o_DATA_OUT_s !== 32'h0 || o_FIRST_s !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got vld=%b data=%h first=%b, want 0/0/0",
               o_VALID_s, o_DATA_OUT_s, o_FIRST_s);
    end
    n_vec++;
    if (o_READY_s !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b, want 1", o_READY_s);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] tot [4] = '{32'd5, 32'd12, 32'd12, 32'd7};
    logic [W-1:0] exp [4] = '{32'd5, 32'd7, 32'd0, 32'hFFFF_FFFB};
    i_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_DATA_IN = tot[i];
      i_VALID   = 1'b1;
      step();
      n_vec++;
      if (o_VALID_s !== 1'b1 || o_DATA_OUT_s !== exp[i] || o_FIRST_s !== (i == 0)) begin
        n_err++;
        $display("FAIL basic[%0d]: got vld=%b data=%h first=%b, want 1/%h/%b",
                 i, o_VALID_s, o_DATA_OUT_s, o_FIRST_s, exp[i], (i == 0));
      end
    end
    i_VALID = 1'b0;
    step();
    n_vec++;
    if (o_VALID_s !== 1'b0) begin
      n_err++;
      $display("FAIL basic_drain: got vld=%b, want 0", o_VALID_s);
    end
  endtask

  task automatic test_wrap();
    i_READY   = 1'b1;
    i_VALID   = 1'b1;
    i_DATA_IN = 32'hFFFF_FFE0;
    step();
    n_vec++;
    if (o_VALID_s !== 1'b1 || o_DATA_OUT_s !== 32'hFFFF_FFD9) begin
      n_err++;
      $display("FAIL wrap_first: got vld=%b data=%h, want 1/ffffffd9", o_VALID_s, o_DATA_OUT_s);
    end
    i_DATA_IN = 32'h0000_0010;
    step();
    n_vec++;
    if (o_VALID_s !== 1'b1 || o_DATA_OUT_s !== 32'h0000_0030) begin
      n_err++;
      $display("FAIL wrap_second: got vld=%b data=%h, want 1/00000030", o_VALID_s, o_DATA_OUT_s);
    end
    i_VALID = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    i_READY   = 1'b0;
    i_VALID   = 1'b1;
    i_DATA_IN = 32'd100;
    step();
    n_vec++;
    if (o_VALID_s !== 1'b1 || o_DATA_OUT_s !== 32'h54) begin
      n_err++;
      $display("FAIL bp_load: got vld=%b data=%h, want 1/00000054", o_VALID_s, o_DATA_OUT_s);
    end
    i_DATA_IN = 32'd130;
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++;
      if (o_VALID_s !== 1'b1 || o_DATA_OUT_s !== 32'h54 || o_READY_s !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got vld=%b data=%h rdy=%b, want 1/00000054/0",
                 c, o_VALID_s, o_DATA_OUT_s, o_READY_s);
      end
    end
    i_READY = 1'b1;
    #1;
    n_vec++;
    if (o_READY_s !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready_comb: got %b, want 1", o_READY_s);
    end
    step();
    n_vec++;
    if (o_VALID_s !== 1'b1 || o_DATA_OUT_s !== 32'd30) begin
      n_err++;
      $display("FAIL bp_release: got vld=%b data=%h, want 1/0000001e", o_VALID_s, o_DATA_OUT_s);
    end
    i_VALID = 1'b0;
    step();
    n_vec++;
    if (o_VALID_s !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: got vld=%b, want 0", o_VALID_s);
    end
  endtask

  task automatic test_clear();
    i_CLEAR = 1'b1;
    step();
    i_CLEAR   = 1'b0;
    i_READY   = 1'b1;
    i_VALID   = 1'b1;
    i_DATA_IN = 32'd100;
    step();
    n_vec++;
    if (o_VALID_s !== 1'b1 || o_DATA_OUT_s !== 32'd100 || o_FIRST_s !== 1'b1) begin
      n_err++;
      $display("FAIL clr_seed: got vld=%b data=%h first=%b, want 1/00000064/1",
               o_VALID_s, o_DATA_OUT_s, o_FIRST_s);
    end
    i_DATA_IN = 32'd150;
    step();
    i_VALID = 1'b0;
    i_READY = 1'b0;
    step();
    n_vec++;
    if (o_VALID_s !== 1'b1 || o_DATA_OUT_s !== 32'd50) begin
      n_err++;
      $display("FAIL clr_pending: got vld=%b data=%h, want 1/00000032", o_VALID_s, o_DATA_OUT_s);
    end
    i_CLEAR = 1'b1;
    i_READY = 1'b1;
    i_VALID = 1'b1;
    i_DATA_IN = 32'd999;
    #1;
    n_vec++;
    if (o_READY_s !== 1'b0) begin
      n_err++;
      $display("FAIL clr_ready: got %b, want 0", o_READY_s);
    end
    step();
    i_CLEAR = 1'b0;
    i_VALID = 1'b0;
    n_vec++;
    if (o_VALID_s !== 1'b0 || o_FIRST_s !== 1'b0) begin
      n_err++;
      $display("FAIL clr_discard: got vld=%b first=%b, want 0/0", o_VALID_s, o_FIRST_s);
    end
    i_VALID   = 1'b1;
    i_DATA_IN = 32'd40;
    step();
    i_VALID = 1'b0;
    n_vec++;
    if (o_VALID_s !== 1'b1 || o_DATA_OUT_s !== 32'd40 || o_FIRST_s !== 1'b1) begin
      n_err++;
      $display("FAIL clr_restart: got vld=%b data=%h first=%b, want 1/00000028/1",
               o_VALID_s, o_DATA_OUT_s, o_FIRST_s);
    end
    step();
  endtask

  task automatic test_prime_mode();
    apply_reset();
    i_READY   = 1'b1;
    i_VALID   = 1'b1;
    i_DATA_IN = 32'd10;
    step();
    n_vec++;
    if (o_VALID_p !== 1'b0) begin
      n_err++;
      $display("FAIL prime_noout: got vld=%b, want 0", o_VALID_p);
    end
    i_DATA_IN = 32'd13;
    step();
    n_vec++;
    if (o_VALID_p !== 1'b1 || o_DATA_OUT_p !== 32'd3 || o_FIRST_p !== 1'b1) begin
      n_err++;
      $display("FAIL prime_first: got vld=%b data=%h first=%b, want 1/00000003/1",
               o_VALID_p, o_DATA_OUT_p, o_FIRST_p);
    end
    i_DATA_IN = 32'd20;
    step();
    n_vec++;
    if (o_VALID_p !== 1'b1 || o_DATA_OUT_p !== 32'd7 || o_FIRST_p !== 1'b0) begin
      n_err++;
      $display("FAIL prime_second: got vld=%b data=%h first=%b, want 1/00000007/0",
               o_VALID_p, o_DATA_OUT_p, o_FIRST_p);
    end
    i_VALID = 1'b0;
    i_READY = 1'b0;
    #2;
    i_RESET = 1'b1;
    #1;
    n_vec++;
    if (o_VALID_p !== 1'b0 || o_DATA_OUT_p !== 32'd0 || o_FIRST_p !== 1'b0 || o_READY_p !== 1'b1) begin
      n_err++;
      $display("FAIL prime_async_reset: got vld=%b data=%h first=%b rdy=%b, want 0/0/0/1",
               o_VALID_p, o_DATA_OUT_p, o_FIRST_p, o_READY_p);
    end
    i_RESET = 1'b0;
    step();
  endtask

  task automatic test_round_trip();
    logic [W-1:0] inc [N_RT];
    logic [W-1:0] tot [N_RT];
    logic [W-1:0] acc;
    int idx;
    int oidx;
    int cyc;
    bit in_x;
    bit out_x;
    acc = '0;
    for (int i = 0; i < N_RT; i++) begin
      inc[i] = $urandom;
      acc    = acc + inc[i];
      tot[i] = acc;
    end
    apply_reset();
    idx  = 0;
    oidx = 0;
    cyc  = 0;
    while (oidx < N_RT && cyc < 20000) begin
      i_VALID   = (idx < N_RT) && ($urandom_range(0, 3) != 0);
      i_DATA_IN = (idx < N_RT) ? tot[idx] : '0;
      i_READY   = ($urandom_range(0, 3) != 0);
      #1;
      in_x  = i_VALID && o_READY_s;
      out_x = o_VALID_s && i_READY;
      if (out_x) begin
        n_vec++;
        if (o_DATA_OUT_s !== inc[oidx] || o_FIRST_s !== (oidx == 0)) begin
          n_err++;
          $display("FAIL round_trip[%0d]: got data=%h first=%b, want %h/%b",
                   oidx, o_DATA_OUT_s, o_FIRST_s, inc[oidx], (oidx == 0));
        end
        oidx++;
      end
      if (in_x) idx++;
      step();
      cyc++;
    end
    i_VALID = 1'b0;
    n_vec++;
    if (oidx != N_RT) begin
      n_err++;
      $display("FAIL round_trip_timeout: got %0d words, want %0d", oidx, N_RT);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_clear();
    test_prime_mode();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
